reg_file32: RTL and testbench

- Integer register file for the RV32I datapath: 32 x 32-bit architectural registers (x0..x31), one synchronous write port, two asynchronous read ports.
- Sits directly upstream of the per-bit 32:1 read-select muxes and the decode/execute boundary.
- Consumes writeback data from the WB stage.
- Supplies rs1/rs2 operands to the ALU operand muxes.

---
 rtl/reg_file32.sv | 105 ++++++++++
 tb/tb_reg_file32.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/reg_file32.sv
// -----------------------------------------------------------------------------
// reg_file32 -- RV32I integer register file
//
// 32 architectural registers x0..x31, each XLEN (32) bits wide. x0 has no
// storage and always reads as zero; x1..x31 are physical flops. There is one
// synchronous write port and two independent asynchronous read ports.
//
// Build option:
//   REGFILE_BYPASS_EN  When defined, a write in flight (we=1, wa!=0) is
//                      forwarded combinationally to any read port whose
//                      address matches wa, in the same cycle. Forwarding is
//                      suppressed while rst is high. When undefined, no
//                      forwarding logic exists and reads return stored state.
//
// Timing is modelled at zero delay. The read path corresponds to 2*T gate
// delays and the register clock-to-q to T, with T = 0.
//
// Ports:
//   clk  in   1     clock, state updates on rising edge
//   rst  in   1     asynchronous active-high reset, clears x1..x31
//   we   in   1     write enable
//   wa   in   5     write address
//   wd   in   XLEN  write data
//   ra1  in   5     read address, port 1 (rs1)
//   ra2  in   5     read address, port 2 (rs2)
//   rd1  out  XLEN  read data, port 1
//   rd2  out  XLEN  read data, port 2
// -----------------------------------------------------------------------------
module reg_file32 #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);

  // Physical storage for x1..x31 only; x0 is synthesised as a constant zero.
  logic [XLEN-1:0] regs [1:31];

  // A write only takes effect for a non-zero destination.
  logic wr_en;
  assign wr_en = we && (wa != 5'd0);

  // ---------------------------------------------------------------------------
  // Write port
  // ---------------------------------------------------------------------------
  // NOTE: this storage is deliberately reset. The datapath relies on every
  // register holding a defined value after reset, so it is built from
  // resettable flops rather than a RAM macro, which could not be cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      // NOTE: non-blocking assignment so every flop samples pre-edge values,
      // regardless of how many processes observe regs in the same time step.
      regs[wa] <= wd;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] stored1;
  logic [XLEN-1:0] stored2;

  // NOTE: each output gets a default before any conditional, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    stored1 = '0;
    stored2 = '0;
    if (ra1 != 5'd0) stored1 = regs[ra1];
    if (ra2 != 5'd0) stored2 = regs[ra2];
  end

`ifdef REGFILE_BYPASS_EN
  // Write-through forwarding. wr_en already excludes x0, so a read of x0 is
  // never forwarded. During reset the storage is already zero, and the forward
  // path is blocked so the in-flight write cannot leak out either.
  logic fwd1;
  logic fwd2;
  assign fwd1 = wr_en && !rst && (ra1 == wa);
  assign fwd2 = wr_en && !rst && (ra2 == wa);

  always_comb begin
    rd1 = stored1;
    rd2 = stored2;
    if (fwd1) rd1 = wd;
    if (fwd2) rd2 = wd;
  end
`else
  // Without forwarding, a same-cycle read of the written register sees the
  // old contents until the edge, then the new value through the normal path.
  assign rd1 = stored1;
  assign rd2 = stored2;
`endif

endmodule

// File: tb/tb_reg_file32.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_reg_file32 -- self-checking bench for reg_file32
//
// A table of single-cycle vectors is applied on falling edges; each vector's
// expected read data is the value the ports must show before the following
// rising edge. Hand-written sequences then cover the register dump, the
// mid-cycle reset sweep and reset winning against a write.
// -----------------------------------------------------------------------------
module tb_reg_file32;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] rd1;
  logic [31:0] rd2;

  int total = 0;
  int bad   = 0;

  reg_file32 #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .we  (we),
    .wa  (wa),
    .wd  (wd),
    .ra1 (ra1),
    .ra2 (ra2),
    .rd1 (rd1),
    .rd2 (rd2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic w, input logic [4:0] a, input logic [31:0] d,
                              input logic [4:0] r1, input logic [4:0] r2,
                              input logic [31:0] x1, input logic [31:0] x2);
    vec_t v;
    v.we = w; v.wa = a; v.wd = d; v.ra1 = r1; v.ra2 = r2; v.e1 = x1; v.e2 = x2;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs just after a falling edge.
  task automatic drive(input logic w, input logic [4:0] a, input logic [31:0] d,
                       input logic [4:0] r1, input logic [4:0] r2);
    @(negedge clk);
    we = w; wa = a; wd = d; ra1 = r1; ra2 = r2;
  endtask

  logic [31:0] dump_exp [32];

  initial begin
    rst = 1'b1; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;

    // Vectors: expectations are pre-edge values, so writes show up from the
    // next vector onward (or in the same vector when forwarding is built in).
    vecs[0]  = mk(1, 5'd5,  32'hDEAD_BEEF, 5'd5,  5'd5,
                  BYP ? 32'hDEAD_BEEF : 32'h0, BYP ? 32'hDEAD_BEEF : 32'h0);
    vecs[1]  = mk(0, 5'd5,  32'h0,         5'd5,  5'd5,  32'hDEAD_BEEF, 32'hDEAD_BEEF);
    vecs[2]  = mk(0, 5'd0,  32'h0,         5'd4,  5'd6,  32'h0,         32'h0);
    vecs[3]  = mk(1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd5,  32'h0,         32'hDEAD_BEEF);
    vecs[4]  = mk(0, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd5,  32'h0,         32'hDEAD_BEEF);
    vecs[5]  = mk(0, 5'd7,  32'h1234_5678, 5'd7,  5'd7,  32'h0,         32'h0);
    vecs[6]  = mk(0, 5'd0,  32'h0,         5'd5,  5'd7,  32'hDEAD_BEEF, 32'h0);
    vecs[7]  = mk(1, 5'd9,  32'h1111_1111, 5'd3,  5'd9,  32'h0,         BYP ? 32'h1111_1111 : 32'h0);
    vecs[8]  = mk(1, 5'd9,  32'h2222_2222, 5'd9,  5'd9,
                  BYP ? 32'h2222_2222 : 32'h1111_1111, BYP ? 32'h2222_2222 : 32'h1111_1111);
    vecs[9]  = mk(0, 5'd0,  32'h0,         5'd9,  5'd5,  32'h2222_2222, 32'hDEAD_BEEF);
    vecs[10] = mk(1, 5'd31, 32'h0000_0001, 5'd31, 5'd30, BYP ? 32'h1 : 32'h0, 32'h0);
    vecs[11] = mk(1, 5'd30, 32'h8000_0000, 5'd31, 5'd30, 32'h1, BYP ? 32'h8000_0000 : 32'h0);
    vecs[12] = mk(0, 5'd0,  32'h0,         5'd30, 5'd31, 32'h8000_0000, 32'h1);

    // Reset state: apply reset first, release on a falling edge.
    repeat (2) @(negedge clk);
    ra1 = 5'd1; ra2 = 5'd31;
    #1;
    check("reset_hold_rd1", rd1, 32'h0);
    check("reset_hold_rd2", rd2, 32'h0);
    rst = 1'b0;
    #1;
    check("reset_rel_rd1", rd1, 32'h0);
    check("reset_rel_rd2", rd2, 32'h0);

    // Table-driven vectors.
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra1, vecs[i].ra2);
      #1;
      check($sformatf("vec%0d_rd1", i), rd1, vecs[i].e1);
      check($sformatf("vec%0d_rd2", i), rd2, vecs[i].e2);
    end

    // Same-cycle read/write, after the edge: new value through the normal path.
    // (vec8 wrote x9; vec9 already checked it, here re-check right after an edge.)
    drive(1, 5'd9, 32'h3333_3333, 5'd9, 5'd0);
    @(posedge clk);
    #1;
    check("rw_after_edge_rd1", rd1, 32'h3333_3333);

    // Full dump: the x0 write and the we=0 write must have changed nothing.
    drive(0, 5'd0, 32'h0, 5'd0, 5'd0);
    for (int i = 0; i < 32; i++) dump_exp[i] = 32'h0;
    dump_exp[5]  = 32'hDEAD_BEEF;
    dump_exp[9]  = 32'h3333_3333;
    dump_exp[30] = 32'h8000_0000;
    dump_exp[31] = 32'h0000_0001;
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i);
      ra2 = 5'(31 - i);
      #0.1;
      check($sformatf("dump_rd1_x%0d", i), rd1, dump_exp[i]);
      check($sformatf("dump_rd2_x%0d", 31 - i), rd2, dump_exp[31 - i]);
    end

    // Reset sweep: preload x1..x31, then pulse rst mid-cycle.
    for (int i = 1; i < 32; i++) begin
      drive(1, 5'(i), 32'hA5A5_0000 + 32'(i), 5'd0, 5'd0);
    end
    drive(0, 5'd0, 32'h0, 5'd1, 5'd31);
    #1;
    check("preload_x1", rd1, 32'hA5A5_0001);
    check("preload_x31", rd2, 32'hA5A5_001F);
    @(posedge clk);
    #2;
    rst = 1'b1;
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i);
      ra2 = 5'(31 - i);
      #0.1;
      check($sformatf("rst_sweep_rd1_x%0d", i), rd1, 32'h0);
      check($sformatf("rst_sweep_rd2_x%0d", 31 - i), rd2, 32'h0);
    end
    #0.5;
    rst = 1'b0;
    ra1 = 5'd17; ra2 = 5'd31;
    #0.5;
    check("rst_sweep_after_rd1", rd1, 32'h0);
    check("rst_sweep_after_rd2", rd2, 32'h0);

    // Reset beats write: rst held across an edge with a write pending.
    drive(1, 5'd31, 32'hCAFE_F00D, 5'd31, 5'd30);
    rst = 1'b1;
    #1;
    check("rst_vs_wr_during_rd1", rd1, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    we  = 1'b0;
    #1;
    check("rst_vs_wr_after_rd1", rd1, 32'h0);
    check("rst_vs_wr_after_rd2", rd2, 32'h0);
    drive(1, 5'd31, 32'hCAFE_F00D, 5'd31, 5'd30);
    @(negedge clk);
    we = 1'b0;
    #1;
    check("post_rst_write_rd1", rd1, 32'hCAFE_F00D);
    check("post_rst_write_rd2", rd2, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
